// File: rtl/cfo_inject.sv
// cfo_inject: applies a carrier frequency offset to a complex sample stream,
// do = di * exp(+j*phi_n). The phase is an 18-bit accumulator and the rotation
// uses a quarter-wave sine table. The pipeline is five stages deep:
// phase, table lookup, quadrant map, multiply, round/saturate.
module cfo_inject #(
  parameter int FRAME_MAX = 9536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] di_re,
  input  logic [11:0] di_im,
  input  logic        di_vld,
  input  logic        start,
  input  logic [17:0] cfg_cfo,
  input  logic        cfg_load,
  input  logic        cfg_bypass,
  output logic [11:0] do_re,
  output logic [11:0] do_im,
  output logic        do_vld,
  output logic        do_last
);

  // Elaboration-time round(1024*sin(2*pi*idx/1024)), computed with a Q30
  // fixed-point Taylor series so the table needs no hand-entered constants.
  function automatic int sin_q10(input int idx);
    longint x;
    longint term;
    longint sum;
    x    = (longint'(idx) * 64'sd6746518852) >>> 10;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'((sum * 64'sd1024 + (64'sd1 <<< 29)) >>> 30);
  endfunction

  // Add the rounding constant, drop 10 fraction bits and clamp to 12 bits.
  function automatic logic [11:0] rnd_sat(input logic signed [24:0] v);
    logic signed [25:0] ve;
    logic signed [25:0] t;
    ve = {v[24], v};
    t  = (ve + 26'sd512) >>> 10;
    if (t > 26'sd2047) begin
      return 12'h7FF;
    end else if (t < -26'sd2048) begin
      return 12'h800;
    end else begin
      return t[11:0];
    end
  endfunction

  logic [10:0] lut_w [0:256];

  for (genvar gi = 0; gi <= 256; gi++) begin : g_lut
    localparam int V = sin_q10(gi);
    assign lut_w[gi] = 11'(V);
  end

  logic [17:0] acc_q, acc_d, inc_q, inc_d, inc_eff;
  logic [13:0] cnt_q, cnt_d;
  logic        s1_vld_q, s1_vld_d, s1_bp_q, s1_bp_d, s1_last_q, s1_last_d;
  logic [9:0]  s1_p_q, s1_p_d;
  logic [11:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic        s2_vld_q, s2_vld_d, s2_bp_q, s2_bp_d, s2_last_q, s2_last_d;
  logic [1:0]  s2_quad_q, s2_quad_d;
  logic [10:0] s2_la_q, s2_la_d, s2_lb_q, s2_lb_d;
  logic [11:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic        s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
  logic signed [11:0] s3_cos_q, s3_cos_d, s3_sin_q, s3_sin_d;
  logic signed [11:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
  logic        s4_vld_q, s4_vld_d, s4_last_q, s4_last_d;
  logic signed [24:0] s4_yr_q, s4_yr_d, s4_yi_q, s4_yi_d;
  logic [11:0] do_re_q, do_re_d, do_im_q, do_im_d;
  logic        do_vld_q, do_vld_d, do_last_q, do_last_d;
  logic signed [23:0] p_rc, p_is, p_rs, p_ic;
  logic signed [11:0] pos_a, pos_b, neg_a, neg_b;

  // Next-state logic for the phase/counter front end and every pipeline stage.
  always_comb begin
    acc_d = acc_q;  inc_d = inc_q;  cnt_d = cnt_q;
    inc_eff = cfg_load ? cfg_cfo : inc_q;
    s1_vld_d = di_vld;  s1_bp_d = cfg_bypass;  s1_last_d = 1'b0;
    s1_p_d = 10'd0;  s1_re_d = di_re;  s1_im_d = di_im;
    inc_d = inc_eff;
    if (di_vld) begin
      if (start) begin
        // Frame start: this sample is rotated by phase 0, next one by inc.
        s1_p_d    = 10'd0;
        acc_d     = inc_eff;
        cnt_d     = 14'd1;
        s1_last_d = (14'd0 == 14'(FRAME_MAX - 1));
      end else begin
        s1_p_d    = acc_q[17:8];
        acc_d     = acc_q + inc_eff;
        cnt_d     = (cnt_q == 14'(FRAME_MAX)) ? cnt_q : cnt_q + 14'd1;
        s1_last_d = (cnt_q == 14'(FRAME_MAX - 1));
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end

    // Stage 2: fetch L[a] and L[256-a]; the quadrant picks between them later.
    s2_vld_d  = s1_vld_q;  s2_bp_d = s1_bp_q;  s2_last_d = s1_last_q;
    s2_quad_d = s1_p_q[9:8];
    s2_la_d   = lut_w[{1'b0, s1_p_q[7:0]}];
    s2_lb_d   = lut_w[9'd256 - {1'b0, s1_p_q[7:0]}];
    s2_re_d   = s1_re_q;  s2_im_d = s1_im_q;

    // Stage 3: cos uses the quadrant one step ahead of sin.
    pos_a = {1'b0, s2_la_q};
    pos_b = {1'b0, s2_lb_q};
    neg_a = 12'sd0 - pos_a;
    neg_b = 12'sd0 - pos_b;
    s3_vld_d = s2_vld_q;  s3_last_d = s2_last_q;
    s3_re_d  = s2_re_q;   s3_im_d   = s2_im_q;
    case (s2_quad_q)
      2'd0:    begin s3_sin_d = pos_a; s3_cos_d = pos_b; end
      2'd1:    begin s3_sin_d = pos_b; s3_cos_d = neg_a; end
      2'd2:    begin s3_sin_d = neg_a; s3_cos_d = neg_b; end
      2'd3:    begin s3_sin_d = neg_b; s3_cos_d = pos_a; end
      default: begin s3_sin_d = 12'sd0; s3_cos_d = 12'sd1024; end
    endcase
    if (s2_bp_q) begin
      s3_sin_d = 12'sd0;
      s3_cos_d = 12'sd1024;
    end else begin
      s3_sin_d = s3_sin_d;
    end

    // Stage 4: complex multiply at full width.
    p_rc = s3_re_q * s3_cos_q;
    p_is = s3_im_q * s3_sin_q;
    p_rs = s3_re_q * s3_sin_q;
    p_ic = s3_im_q * s3_cos_q;
    s4_vld_d  = s3_vld_q;  s4_last_d = s3_last_q;
    s4_yr_d   = {p_rc[23], p_rc} - {p_is[23], p_is};
    s4_yi_d   = {p_rs[23], p_rs} + {p_ic[23], p_ic};

    // Stage 5: round/saturate; data holds its last value between valids.
    do_vld_d  = s4_vld_q;
    do_last_d = s4_vld_q & s4_last_q;
    if (s4_vld_q) begin
      do_re_d = rnd_sat(s4_yr_q);
      do_im_d = rnd_sat(s4_yi_q);
    end else begin
      do_re_d = do_re_q;
      do_im_d = do_im_q;
    end
  end

  // State registers; reset clears phase, increment, counter, valids and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 18'd0;  inc_q <= 18'd0;  cnt_q <= 14'd0;
      s1_vld_q <= 1'b0; s1_bp_q <= 1'b0; s1_last_q <= 1'b0; s1_p_q <= 10'd0;
      s1_re_q <= 12'd0; s1_im_q <= 12'd0;
      s2_vld_q <= 1'b0; s2_bp_q <= 1'b0; s2_last_q <= 1'b0; s2_quad_q <= 2'd0;
      s2_la_q <= 11'd0; s2_lb_q <= 11'd0; s2_re_q <= 12'd0; s2_im_q <= 12'd0;
      s3_vld_q <= 1'b0; s3_last_q <= 1'b0; s3_cos_q <= 12'sd0; s3_sin_q <= 12'sd0;
      s3_re_q <= 12'sd0; s3_im_q <= 12'sd0;
      s4_vld_q <= 1'b0; s4_last_q <= 1'b0; s4_yr_q <= 25'sd0; s4_yi_q <= 25'sd0;
      do_re_q <= 12'd0; do_im_q <= 12'd0; do_vld_q <= 1'b0; do_last_q <= 1'b0;
    end else begin
      acc_q <= acc_d;  inc_q <= inc_d;  cnt_q <= cnt_d;
      s1_vld_q <= s1_vld_d; s1_bp_q <= s1_bp_d; s1_last_q <= s1_last_d; s1_p_q <= s1_p_d;
      s1_re_q <= s1_re_d; s1_im_q <= s1_im_d;
      s2_vld_q <= s2_vld_d; s2_bp_q <= s2_bp_d; s2_last_q <= s2_last_d; s2_quad_q <= s2_quad_d;
      s2_la_q <= s2_la_d; s2_lb_q <= s2_lb_d; s2_re_q <= s2_re_d; s2_im_q <= s2_im_d;
      s3_vld_q <= s3_vld_d; s3_last_q <= s3_last_d; s3_cos_q <= s3_cos_d; s3_sin_q <= s3_sin_d;
      s3_re_q <= s3_re_d; s3_im_q <= s3_im_d;
      s4_vld_q <= s4_vld_d; s4_last_q <= s4_last_d; s4_yr_q <= s4_yr_d; s4_yi_q <= s4_yi_d;
      do_re_q <= do_re_d; do_im_q <= do_im_d; do_vld_q <= do_vld_d; do_last_q <= do_last_d;
    end
  end

  assign do_re   = do_re_q;
  assign do_im   = do_im_q;
  assign do_vld  = do_vld_q;
  assign do_last = do_last_q;

endmodule

// File: tb/tb_cfo_inject.sv
// Directed bench for cfo_inject: reset, latency, quarter-turn rotation,
// saturation, phase wrap, mid-frame restart, bypass, frame marker, mid-stream reset.
module tb_cfo_inject;

  logic        clk;
  logic        rst_n;
  logic [11:0] di_re, di_im;
  logic        di_vld, start, cfg_load, cfg_bypass;
  logic [17:0] cfg_cfo;
  logic [11:0] do_re, do_im;
  logic        do_vld, do_last;

  int checks = 0;
  int errors = 0;

  logic signed [11:0] ore [$];
  logic signed [11:0] oim [$];
  int vcnt = 0;
  int lcnt = 0;
  int lidx = -1;

  cfo_inject dut (
    .clk(clk), .rst_n(rst_n), .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .start(start), .cfg_cfo(cfg_cfo), .cfg_load(cfg_load), .cfg_bypass(cfg_bypass),
    .do_re(do_re), .do_im(do_im), .do_vld(do_vld), .do_last(do_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (do_vld) begin
      ore.push_back(do_re);
      oim.push_back(do_im);
      if (do_last) begin
        lcnt = lcnt + 1;
        lidx = vcnt;
      end
      vcnt = vcnt + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re, input int im, input bit st, input bit ld, input int cfo);
    di_re = re[11:0]; di_im = im[11:0];
    di_vld = 1'b1; start = st; cfg_load = ld; cfg_cfo = cfo[17:0];
    tick();
    di_vld = 1'b0; start = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int t;
    t = 0;
    while (ore.size() < n && t < 40) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk(tag, ore.size(), n);
  endtask

  task automatic exp_out(input string tag, input int idx, input int er, input int ei);
    chk({tag, "_re"}, int'(ore[idx]), er);
    chk({tag, "_im"}, int'(oim[idx]), ei);
  endtask

  initial begin
    int base;
    int lbase;
    rst_n = 1'b1; di_re = 12'd0; di_im = 12'd0; di_vld = 1'b0; start = 1'b0;
    cfg_cfo = 18'd0; cfg_load = 1'b0; cfg_bypass = 1'b0;
    #2 rst_n = 1'b0;

    // Reset held with valid toggling: outputs stay zero.
    for (int k = 0; k < 4; k++) begin
      di_vld = ~di_vld; di_re = 12'd77;
      tick();
    end
    di_vld = 1'b0;
    chk("rst_vld", int'(do_vld), 0);
    chk("rst_last", int'(do_last), 0);
    chk("rst_re", int'(do_re), 0);
    chk("rst_im", int'(do_im), 0);
    rst_n = 1'b1;

    // Identity, with exact 5-cycle latency.
    base = ore.size();
    di_re = 12'd100; di_im = -12'sd200; di_vld = 1'b1; start = 1'b1;
    cfg_load = 1'b1; cfg_cfo = 18'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        di_vld = 1'b0; start = 1'b0; cfg_load = 1'b0;
      end
      chk($sformatf("lat_%0d", k), int'(do_vld), (k == 5) ? 1 : 0);
    end
    chk("id_re", int'($signed(do_re)), 100);
    chk("id_im", int'($signed(do_im)), -200);
    tick();
    chk("vld_pulse", int'(do_vld), 0);
    chk("hold_re", int'($signed(do_re)), 100);

    // Quarter-turn with a one-cycle gap before the last sample.
    base = ore.size();
    send(1000, 0, 1'b1, 1'b1, 65536);
    send(1000, 0, 1'b0, 1'b0, 0);
    send(1000, 0, 1'b0, 1'b0, 0);
    tick();
    send(1000, 0, 1'b0, 1'b0, 0);
    wait_out("qt_n", base + 4);
    exp_out("qt0", base + 0, 1000, 0);
    exp_out("qt1", base + 1, 0, 1000);
    exp_out("qt2", base + 2, -1000, 0);
    exp_out("qt3", base + 3, 0, -1000);

    // Saturation at pi/4 and at pi/2.
    base = ore.size();
    send(0, 0, 1'b1, 1'b1, 32768);
    send(2047, 2047, 1'b0, 1'b0, 0);
    send(0, 0, 1'b1, 1'b1, 65536);
    send(-2048, -2048, 1'b0, 1'b0, 0);
    wait_out("sat_n", base + 4);
    exp_out("sat45", base + 1, 0, 2047);
    exp_out("sat90", base + 3, 2047, -2048);

    // Negative increment wraps; a mid-frame start returns to phase 0.
    base = ore.size();
    send(1000, 0, 1'b1, 1'b1, 196608);
    send(1000, 0, 1'b0, 1'b0, 0);
    send(1000, 0, 1'b1, 1'b0, 0);
    send(1000, 0, 1'b0, 1'b0, 0);
    wait_out("wrap_n", base + 4);
    exp_out("wrap0", base + 0, 1000, 0);
    exp_out("wrap1", base + 1, 0, -1000);
    exp_out("restart", base + 2, 1000, 0);
    exp_out("restart1", base + 3, 0, -1000);

    // Bypass passes data exactly even with a nonzero increment.
    base = ore.size();
    cfg_bypass = 1'b1;
    send(123, -456, 1'b1, 1'b1, 65536);
    send(-2048, 2047, 1'b0, 1'b0, 0);
    send(2047, -2048, 1'b0, 1'b0, 0);
    cfg_bypass = 1'b0;
    wait_out("bp_n", base + 3);
    exp_out("bp0", base + 0, 123, -456);
    exp_out("bp1", base + 1, -2048, 2047);
    exp_out("bp2", base + 2, 2047, -2048);

    // Frame of FRAME_MAX+3 samples: exactly one do_last, on output 9535.
    base = vcnt;
    lbase = lcnt;
    di_re = 12'd5; di_im = 12'd7; cfg_cfo = 18'd0; cfg_load = 1'b1;
    di_vld = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; cfg_load = 1'b0;
    repeat (9538) tick();
    di_vld = 1'b0;
    wait_out("frm_n", base + 9539);
    chk("last_cnt", lcnt - lbase, 1);
    chk("last_idx", lidx - base, 9535);

    // Reset mid-stream discards in-flight samples.
    base = vcnt;
    send(300, 300, 1'b1, 1'b1, 0);
    send(300, 300, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rst_flush", vcnt - base, 0);
    chk("rst_out_re", int'(do_re), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
